// File: rtl/leg_imm_pkg.sv
// Shared types and constants for the immediate encoder.
// Optional feature macro: IMM_ENC_NEG_EN (adds ~V and -V search passes).
package leg_imm_pkg;

    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_HALF = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        DONE   = 2'b10
    } enc_state_t;

    typedef enum logic [1:0] {
        ALT_DIRECT = 2'b00,
        ALT_NOT    = 2'b01,
        ALT_NEG    = 2'b10
    } alt_t;

    localparam int          ROT_STEPS    = 16;
    localparam logic [31:0] MEM_IMM_MAX  = 32'd4096;
    localparam logic [31:0] HALF_IMM_MAX = 32'd256;

    typedef struct packed {
        logic [23:0] field;
        logic        ok;
        alt_t        alt;
    } enc_result_t;

    // Rotate left by an even amount up to 30 bits.
    function automatic logic [31:0] rol32(
        input logic [31:0] v,
        input logic [4:0]  amt
    );
        logic [63:0] d;
        d = {v, v} << amt;
        return d[63:32];
    endfunction

endpackage

// File: rtl/imm_encoder_rot_check.sv
// Single-rotation probe: does rol(value, 2*rot) fit in eight bits.
// Purely combinational; the encoder steps rot once per cycle.
module imm_rot_check
    import leg_imm_pkg::*;
(
    input  logic [31:0] Value,
    input  logic [3:0]  rot,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [31:0] rotated;

    // Rotate and test that only the low byte remains populated.
    always_comb begin
        rotated = rol32(Value, {rot, 1'b0});
        hit     = (rotated[31:8] == 24'd0);
        imm8    = rotated[7:0];
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: 32-bit constant + format -> 24-bit instruction field.
// Build option IMM_ENC_NEG_EN: rotated search retries on ~V then -V.
module imm_encoder
    import leg_imm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Value,
    input  logic [1:0]  ImmSrc,
    input  logic        RiType,
    input  logic        SignExtend,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] Field,
    output logic        Ok,
    output logic [1:0]  Alt
);

    enc_state_t  state;
    enc_state_t  state_nx;
    logic [31:0] value_q;
    logic [3:0]  rot_q;
    enc_result_t res_q;
    enc_result_t direct_res;

    logic        accept;
    logic        go_search;
    logic        last_rot;
    logic        last_pass;
    logic        search_exit;
    logic [31:0] cand;
    alt_t        cur_alt;
    logic        rot_hit;
    logic [7:0]  rot_imm8;

    assign accept    = in_valid & in_ready;
    assign go_search = (imm_src_t'(ImmSrc) == IMM_DP) & RiType;
    assign last_rot  = (rot_q == 4'(ROT_STEPS - 1));

    assign search_exit = (state == SEARCH)
                       & (rot_hit | (last_rot & last_pass));

    imm_rot_check u_rot (
        .Value (cand),
        .rot   (rot_q),
        .hit   (rot_hit),
        .imm8  (rot_imm8)
    );

`ifdef IMM_ENC_NEG_EN
    logic [1:0] pass_q;

    // Select the candidate for the current pass: V, ~V, then -V.
    always_comb begin
        cand      = value_q;
        cur_alt   = ALT_DIRECT;
        last_pass = 1'b0;
        case (pass_q)
            2'd0: begin
                cand    = value_q;
                cur_alt = ALT_DIRECT;
            end
            2'd1: begin
                cand    = ~value_q;
                cur_alt = ALT_NOT;
            end
            default: begin
                cand      = 32'd0 - value_q;
                cur_alt   = ALT_NEG;
                last_pass = 1'b1;
            end
        endcase
    end

    // Advance the pass after each full sweep of rotations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_q <= 2'd0;
        end else if (accept) begin
            pass_q <= 2'd0;
        end else if (state == SEARCH) begin
            if (search_exit)
                pass_q <= 2'd0;
            else if (last_rot)
                pass_q <= pass_q + 2'd1;
        end
    end
`else
    assign cand      = value_q;
    assign cur_alt   = ALT_DIRECT;
    assign last_pass = 1'b1;
`endif

    // Formats that encode in one step, resolved at accept time.
    always_comb begin
        direct_res = '0;
        unique case (imm_src_t'(ImmSrc))
            IMM_DP: begin
                direct_res.ok    = (Value < MEM_IMM_MAX);
                direct_res.field = {12'd0, Value[11:0]};
            end
            IMM_MEM: begin
                if (SignExtend)
                    direct_res.ok = (Value[31:11] == '0)
                                  | (Value[31:11] == '1);
                else
                    direct_res.ok = (Value < MEM_IMM_MAX);
                direct_res.field = {12'd0, Value[11:0]};
            end
            IMM_BR: begin
                direct_res.ok = (Value[1:0] == 2'b00)
                              & (Value[31:25] == {7{Value[25]}});
                direct_res.field = Value[25:2];
            end
            IMM_HALF: begin
                direct_res.ok    = (Value < HALF_IMM_MAX);
                direct_res.field = {12'd0, Value[7:4],
                                    4'd0, Value[3:0]};
            end
        endcase
        if (!direct_res.ok)
            direct_res.field = '0;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nx = go_search ? SEARCH : DONE;
            end
            SEARCH: begin
                if (search_exit)
                    state_nx = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        Field     = res_q.field;
        Ok        = res_q.ok;
        Alt       = res_q.alt;
    end

    // Request latch, rotation counter and result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            rot_q   <= '0;
            res_q   <= '0;
        end else if (accept) begin
            value_q <= Value;
            rot_q   <= '0;
            res_q   <= go_search ? '0 : direct_res;
        end else if (state == SEARCH) begin
            if (search_exit) begin
                rot_q <= '0;
                if (rot_hit) begin
                    res_q.field <= {12'd0, rot_q, rot_imm8};
                    res_q.ok    <= 1'b1;
                    res_q.alt   <= cur_alt;
                end else begin
                    res_q <= '0;
                end
            end else begin
                rot_q <= rot_q + 4'd1;
            end
        end else if ((state == DONE) && out_ready) begin
            res_q <= '0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors plus random
// requests against a behavioural model of the encoding rules.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Value = '0;
    logic [1:0]  ImmSrc = '0;
    logic        RiType = 1'b0;
    logic        SignExtend = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] Field;
    logic        Ok;
    logic [1:0]  Alt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef IMM_ENC_NEG_EN
    localparam int NPASS = 3;
`else
    localparam int NPASS = 1;
`endif

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Value      (Value),
        .ImmSrc     (ImmSrc),
        .RiType     (RiType),
        .SignExtend (SignExtend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Field      (Field),
        .Ok         (Ok),
        .Alt        (Alt)
    );

    function automatic logic [31:0] rol_n(input logic [31:0] v,
                                          input int n);
        logic [31:0] x;
        x = v;
        for (int i = 0; i < n; i++)
            x = {x[30:0], x[31]};
        return x;
    endfunction

    // Reference: encoding rules evaluated directly, plus latency.
    task automatic model(input logic [31:0] v, input logic [1:0] src,
                         input logic ri, input logic se,
                         output logic [23:0] f, output logic ok,
                         output logic [1:0] alt, output int lat);
        logic [31:0] cand;
        logic [31:0] x;
        f = '0; ok = 1'b0; alt = 2'b00; lat = 1;
        if (src == 2'b00 && ri) begin
            lat = 16 * NPASS + 1;
            for (int p = 0; p < NPASS; p++) begin
                cand = (p == 0) ? v : (p == 1) ? ~v : (32'd0 - v);
                for (int r = 0; r < 16; r++) begin
                    x = rol_n(cand, 2 * r);
                    if (!ok && x < 256) begin
                        ok  = 1'b1;
                        f   = {12'd0, 4'(r), x[7:0]};
                        alt = 2'(p);
                        lat = 2 + 16 * p + r;
                    end
                end
            end
        end else begin
            case (src)
                2'b00: begin
                    ok = (v < 4096);
                    f  = 24'(v & 32'hFFF);
                end
                2'b01: begin
                    if (se)
                        ok = ($signed(v) >= -2048) && ($signed(v) <= 2047);
                    else
                        ok = (v < 4096);
                    f = 24'(v & 32'hFFF);
                end
                2'b10: begin
                    ok = (v % 4 == 0) && ($signed(v) >= -(1 << 25))
                         && ($signed(v) < (1 << 25));
                    f = 24'(v >> 2);
                end
                default: begin
                    ok = (v < 256);
                    f  = 24'(((v >> 4) << 8) | (v & 32'hF));
                end
            endcase
            if (!ok) f = '0;
        end
    endtask

    // Drive one request; returns cycles from accept edge to out_valid.
    task automatic do_req(input logic [31:0] v, input logic [1:0] src,
                          input logic ri, input logic se,
                          output int lat, output bit to);
        int guard;
        guard = 0;
        to = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        Value = v; ImmSrc = src; RiType = ri; SignExtend = se;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Value = $urandom;
        ImmSrc = 2'($urandom);
        RiType = 1'($urandom);
        SignExtend = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        if (!out_valid) to = 1'b1;
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({out_valid, Field, Ok, Alt, in_ready} !== {1'b0, 24'd0, 1'b0, 2'b00, 1'b1}) begin
            n_bad++;
            $display("FAIL reset: out_valid=%0b Field=%h Ok=%0b Alt=%0b in_ready=%0b, want 0/000000/0/0/1",
                     out_valid, Field, Ok, Alt, in_ready);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_one(input string name, input logic [31:0] v,
                             input logic [1:0] src, input logic ri,
                             input logic se, input logic [23:0] ef,
                             input logic eok, input logic [1:0] ealt,
                             input int elat);
        int lat;
        bit to;
        do_req(v, src, ri, se, lat, to);
        n_cmp++;
        if (to || Field !== ef || Ok !== eok || Alt !== ealt || lat != elat) begin
            n_bad++;
            $display("FAIL %s: V=%h to=%0b Field=%h Ok=%0b Alt=%0b lat=%0d, want Field=%h Ok=%0b Alt=%0b lat=%0d",
                     name, v, to, Field, Ok, Alt, lat, ef, eok, ealt, elat);
        end
        if (!to) finish_out();
    endtask

    task automatic test_directed();
        check_one("rot_ff", 32'h000000FF, 2'b00, 1'b1, 1'b0, 24'h0000FF, 1'b1, 2'b00, 2);
        check_one("rot_r4", 32'hFF000000, 2'b00, 1'b1, 1'b0, 24'h0004FF, 1'b1, 2'b00, 6);
        check_one("rot_zero", 32'h00000000, 2'b00, 1'b1, 1'b0, 24'h000000, 1'b1, 2'b00, 2);
`ifdef IMM_ENC_NEG_EN
        check_one("rot_miss", 32'h00000101, 2'b00, 1'b1, 1'b0, 24'h0, 1'b0, 2'b00, 49);
        check_one("rot_not", 32'hFFFFFF00, 2'b00, 1'b1, 1'b0, 24'h0000FF, 1'b1, 2'b01, 18);
`else
        check_one("rot_miss", 32'h00000101, 2'b00, 1'b1, 1'b0, 24'h0, 1'b0, 2'b00, 17);
        check_one("rot_not", 32'hFFFFFF00, 2'b00, 1'b1, 1'b0, 24'h0, 1'b0, 2'b00, 17);
`endif
        check_one("dp12_ok", 32'h00000FFF, 2'b00, 1'b0, 1'b0, 24'h000FFF, 1'b1, 2'b00, 1);
        check_one("dp12_bad", 32'h00001000, 2'b00, 1'b0, 1'b0, 24'h0, 1'b0, 2'b00, 1);
        check_one("br_ok", 32'hFFFFFFF8, 2'b10, 1'b0, 1'b0, 24'hFFFFFE, 1'b1, 2'b00, 1);
        check_one("br_bad", 32'h00000006, 2'b10, 1'b0, 1'b0, 24'h0, 1'b0, 2'b00, 1);
        check_one("half_ok", 32'h000000AB, 2'b11, 1'b0, 1'b0, 24'h000A0B, 1'b1, 2'b00, 1);
        check_one("half_bad", 32'h00000100, 2'b11, 1'b0, 1'b0, 24'h0, 1'b0, 2'b00, 1);
        check_one("mem_s_ok", 32'hFFFFF800, 2'b01, 1'b0, 1'b1, 24'h000800, 1'b1, 2'b00, 1);
        check_one("mem_s_bad", 32'hFFFFF7FF, 2'b01, 1'b0, 1'b1, 24'h0, 1'b0, 2'b00, 1);
        check_one("mem_u_bad", 32'hFFFFF800, 2'b01, 1'b0, 1'b0, 24'h0, 1'b0, 2'b00, 1);
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [1:0]  src;
        logic        ri, se;
        logic [23:0] ef;
        logic        eok;
        logic [1:0]  ealt;
        int          elat, lat;
        bit          to;
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = rol_n(32'($urandom_range(0, 255)), $urandom_range(0, 31));
                2: v = 32'($urandom_range(0, 5000));
                3: v = 32'd0 - 32'($urandom_range(0, 5000));
                default: v = ~rol_n(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
            endcase
            src = 2'($urandom);
            ri  = 1'($urandom);
            se  = 1'($urandom);
            model(v, src, ri, se, ef, eok, ealt, elat);
            do_req(v, src, ri, se, lat, to);
            n_cmp++;
            if (to || Field !== ef || Ok !== eok || Alt !== ealt || lat != elat) begin
                n_bad++;
                $display("FAIL random: V=%h src=%0d ri=%0b se=%0b to=%0b Field=%h Ok=%0b Alt=%0b lat=%0d, want %h/%0b/%0b/%0d",
                         v, src, ri, se, to, Field, Ok, Alt, lat, ef, eok, ealt, elat);
            end
            if (!to) finish_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        bit bad;
        do_req(32'h000000AB, 2'b11, 1'b0, 1'b0, lat, to);
        bad = to;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || Field !== 24'h000A0B || Ok !== 1'b1)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL backpressure: out_valid=%0b in_ready=%0b Field=%h Ok=%0b, want 1/0/000a0b/1",
                     out_valid, in_ready, Field, Ok);
        end
        if (!to) finish_out();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release: out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            do_req(32'h00000010 << (2 * i), 2'b00, 1'b0, 1'b0, lat, to);
            n_cmp++;
            if (to || Field !== 24'(32'h10 << (2 * i)) || Ok !== 1'b1 || lat != 1) begin
                n_bad++;
                $display("FAIL b2b_%0d: Field=%h Ok=%0b lat=%0d, want %h/1/1",
                         i, Field, Ok, lat, 24'(32'h10 << (2 * i)));
            end
            if (!to) finish_out();
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_idle_%0d: out_valid=%0b in_ready=%0b, want 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_mid_search();
        bit seen;
        @(negedge clk);
        Value = 32'h00000101; ImmSrc = 2'b00; RiType = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Ok !== 1'b0 || Field !== 24'd0) begin
            n_bad++;
            $display("FAIL mid_reset: out_valid=%0b in_ready=%0b Ok=%0b Field=%h, want 0/1/0/0",
                     out_valid, in_ready, Ok, Field);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL mid_reset_quiet: out_valid=1 after abandoned request, want 0");
        end
        check_one("after_reset", 32'hFF000000, 2'b00, 1'b1, 1'b0, 24'h0004FF, 1'b1, 2'b00, 6);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_search();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
